// File: rtl/tx_feed_fifo.sv
// Transmit-side feeder for the 4-phase synchronizer: buffers producer words
// and launches them one at a time, holding each until the synchronizer returns snt.
module tx_feed_fifo #(
    parameter int DATA_MSB = 7,
    parameter int DEPTH    = 4,
    parameter int AW       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_MSB:0] in_data,
    output logic              in_ready,
    output logic              vi,
    output logic [DATA_MSB:0] sdata,
    input  logic              snt,
    output logic [AW:0]       count,
    output logic              busy,
    output logic              err
);

    // Producer handshake: a word transfers on every rising edge where
    // in_valid && in_ready; in_ready comes only from registered occupancy.
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_WAIT  = 1'b1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              vi_q, vi_d;
    logic [DATA_MSB:0] sdata_q, sdata_d;
    logic              err_q, err_d;
    logic [DATA_MSB:0] mem_q [DEPTH];

    logic push;
    logic pop;

    assign in_ready = (count_q != CNT_FULL);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        vi_d    = 1'b0;
        sdata_d = sdata_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // snt with nothing in flight is a protocol error, never a pop
                if (snt) begin
                    err_d = 1'b1;
                end
                if (count_q != '0) begin
                    vi_d    = 1'b1;
                    sdata_d = mem_q[rd_ptr_q];
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (snt) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vi_q     <= 1'b0;
            sdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vi_q     <= vi_d;
            sdata_q  <= sdata_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign vi    = vi_q;
    assign sdata = sdata_q;
    assign count = count_q;
    assign busy  = (state_q == ST_WAIT);
    assign err   = err_q;

    a_vi_single: assert property (@(posedge clk) disable iff (!reset) vi_q |=> !vi_q);
    a_vi_busy:   assert property (@(posedge clk) disable iff (!reset) vi_q |-> busy);
    a_cnt_range: assert property (@(posedge clk) disable iff (!reset) count_q <= CNT_FULL);
    a_err_stick: assert property (@(posedge clk) disable iff (!reset) err_q |=> err_q);

endmodule

// File: tb/tb_tx_feed_fifo.sv
// Bench for tx_feed_fifo: directed scenarios plus random streaming, checked
// against a queue-based reference model and an in-order delivery scoreboard.
module tb_tx_feed_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       vi;
    logic [7:0] sdata;
    logic       snt = 1'b0;
    logic [2:0] count;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;
    int n_vi = 0;

    tx_feed_fifo #(.DATA_MSB(7), .DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .vi(vi), .sdata(sdata), .snt(snt),
        .count(count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: buffered words (including the in-flight one) as a queue.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_busy, m_vi, m_err, m_push;
    logic [7:0] m_sdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_busy = 0; m_vi = 0; m_err = 0; m_sdata = '0; m_push = 0;
        end else begin
            m_push = in_valid && (m_q.size() != DEPTH);
            if (!m_busy) begin
                if (snt) m_err = 1;
                if (m_q.size() != 0) begin
                    m_sdata = m_q[0];
                    m_vi = 1;
                    m_busy = 1;
                end else begin
                    m_vi = 0;
                end
            end else begin
                m_vi = 0;
                if (snt) begin
                    m_q.delete(0);
                    m_busy = 0;
                end
            end
            if (m_push) begin
                m_q.push_back(in_data);
                exp_q.push_back(in_data);
            end
        end
    end

    // Scoreboard: every launch must present the oldest accepted, undelivered word.
    logic prev_vi = 0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_vi = 0;
        end else begin
            if (vi) begin
                n_vi++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sdata_order: launch of %h with no word expected", sdata);
                end else begin
                    if (sdata !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL sdata_order: got %h expected %h", sdata, exp_q[0]);
                    end
                    exp_q.delete(0);
                end
                if (prev_vi) begin
                    miscompares++;
                    $display("FAIL vi_double: vi high two cycles, got 1 expected 0");
                end
            end
            prev_vi = vi;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answers each launch with snt after a fixed delay until the FIFO is empty.
    task automatic drain(input int delay, output bit done);
        int wait_c = 0;
        bit pending = 0;
        done = 0;
        in_valid = 0;
        for (int c = 0; c < 300; c++) begin
            snt = 0;
            if (count == 0 && !busy) begin
                done = 1;
                break;
            end
            if (busy && !pending) begin
                pending = 1;
                wait_c = delay;
            end
            if (pending) begin
                wait_c--;
                if (wait_c == 0) begin
                    snt = 1;
                    pending = 0;
                end
            end
            tick();
        end
        snt = 0;
    endtask

    task automatic test_reset();
        reset = 0; in_valid = 0; snt = 0;
        repeat (3) tick();
        vectors++; if (vi !== 1'b0) begin miscompares++; $display("FAIL reset_vi: got %b expected 0", vi); end
        vectors++; if (sdata !== 8'h00) begin miscompares++; $display("FAIL reset_sdata: got %h expected 00", sdata); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({vi, sdata, count, in_ready, busy, err} !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL idle_quiet: cycle %0d vi=%b sdata=%h count=%0d ready=%b busy=%b err=%b expected 0 00 0 1 0 0",
                         i, vi, sdata, count, in_ready, busy, err);
            end
        end
    endtask

    task automatic test_single_word();
        in_valid = 1; in_data = 8'hA5;
        tick();
        in_valid = 0;
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", count); end
        vectors++; if (vi !== 1'b0) begin miscompares++; $display("FAIL single_vi_early: got %b expected 0", vi); end
        tick();
        vectors++; if (vi !== 1'b1) begin miscompares++; $display("FAIL single_vi: got %b expected 1", vi); end
        vectors++; if (sdata !== 8'hA5) begin miscompares++; $display("FAIL single_sdata: got %h expected a5", sdata); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({vi, busy, sdata} !== {1'b0, 1'b1, 8'hA5}) begin
                miscompares++;
                $display("FAIL single_hold: vi=%b busy=%b sdata=%h expected 0 1 a5", vi, busy, sdata);
            end
        end
        snt = 1;
        tick();
        snt = 0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_pop: count got %0d expected 0", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_release: busy got %b expected 0", busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (vi !== 1'b0) begin miscompares++; $display("FAIL single_no_relaunch: vi got %b expected 0", vi); end
        end
    endtask

    task automatic test_fill();
        int n0 = n_vi;
        bit done;
        for (int w = 1; w <= 4; w++) begin
            in_valid = 1; in_data = 8'(w);
            tick();
        end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d expected 4", count); end
        in_data = 8'h05;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_backpressure: ready got %b expected 0", in_ready); end
            tick();
        end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_hold: count got %0d expected 4", count); end
        snt = 1;
        tick();
        snt = 0;
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL fill_pop: count got %0d expected 3", count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 0;
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_accept5: count got %0d expected 4", count); end
        vectors++; if ({vi, sdata} !== {1'b1, 8'h02}) begin miscompares++; $display("FAIL fill_next: vi=%b sdata=%h expected 1 02", vi, sdata); end
        drain(2, done);
        vectors++; if (!done) begin miscompares++; $display("FAIL fill_drain: timeout, got 0 expected 1"); end
        vectors++; if (n_vi - n0 !== 5) begin miscompares++; $display("FAIL fill_launches: got %0d expected 5", n_vi - n0); end
    endtask

    task automatic test_stream(input int n_words, input int min_d, input int max_d, input bit rand_valid);
        int n0 = n_vi;
        int sent = 0;
        int wait_c = 0;
        int cyc;
        bit pending = 0;
        bit rdy;
        for (cyc = 0; cyc < 3000; cyc++) begin
            vectors++;
            if (int'(count) !== m_q.size() || busy !== m_busy || vi !== m_vi || err !== m_err ||
                sdata !== m_sdata || in_ready !== (m_q.size() != DEPTH)) begin
                miscompares++;
                $display("FAIL stream_model: count=%0d busy=%b vi=%b err=%b sdata=%h ready=%b expected %0d %b %b %b %h %b",
                         count, busy, vi, err, sdata, in_ready, m_q.size(), m_busy, m_vi, m_err, m_sdata,
                         m_q.size() != DEPTH);
            end
            if (sent == n_words && count == 0 && !busy) break;
            snt = 0;
            if (busy && !pending) begin
                pending = 1;
                wait_c = $urandom_range(max_d, min_d);
            end
            if (pending) begin
                wait_c--;
                if (wait_c == 0) begin
                    snt = 1;
                    pending = 0;
                end
            end
            if (!in_valid && sent < n_words && (!rand_valid || $urandom_range(1, 0) == 1)) begin
                in_valid = 1;
                in_data = 8'($urandom);
            end
            rdy = in_ready;
            tick();
            if (in_valid && rdy) begin
                sent++;
                in_valid = 0;
            end
        end
        in_valid = 0; snt = 0;
        vectors++; if (cyc >= 3000) begin miscompares++; $display("FAIL stream_timeout: sent %0d of %0d", sent, n_words); end
        vectors++; if (n_vi - n0 !== n_words) begin miscompares++; $display("FAIL stream_launches: got %0d expected %0d", n_vi - n0, n_words); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_simul_push_pop();
        int n0 = n_vi;
        bit done;
        in_valid = 1; in_data = 8'($urandom);
        tick();
        in_data = 8'($urandom);
        tick();
        vectors++; if ({count, busy} !== {3'd2, 1'b1}) begin miscompares++; $display("FAIL simul_setup: count=%0d busy=%b expected 2 1", count, busy); end
        in_data = 8'($urandom);
        snt = 1;
        tick();
        in_valid = 0; snt = 0;
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL simul_count: got %0d expected 2", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_busy: got %b expected 0", busy); end
        drain(1, done);
        vectors++; if (!done) begin miscompares++; $display("FAIL simul_drain: timeout, got 0 expected 1"); end
        vectors++; if (n_vi - n0 !== 3) begin miscompares++; $display("FAIL simul_launches: got %0d expected 3", n_vi - n0); end
    endtask

    task automatic test_spurious_reset();
        snt = 1;
        tick();
        snt = 0;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL spurious_err: got %b expected 1", err); end
        vectors++; if ({count, busy, vi} !== {3'd0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL spurious_state: count=%0d busy=%b vi=%b expected 0 0 0", count, busy, vi); end
        for (int w = 0; w < 3; w++) begin
            in_valid = 1; in_data = 8'($urandom);
            tick();
        end
        in_valid = 0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midflight_busy: got %b expected 1", busy); end
        reset = 0;
        #1;
        vectors++; if (vi !== 1'b0) begin miscompares++; $display("FAIL rst_vi: got %b expected 0", vi); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err); end
        vectors++; if ({busy, in_ready, sdata} !== {1'b0, 1'b1, 8'h00}) begin miscompares++; $display("FAIL rst_misc: busy=%b ready=%b sdata=%h expected 0 1 00", busy, in_ready, sdata); end
        tick();
        reset = 1;
        tick();
        snt = 1;
        tick();
        snt = 0;
        vectors++; if ({err, count, busy} !== {1'b1, 3'd0, 1'b0}) begin miscompares++; $display("FAIL late_snt: err=%b count=%0d busy=%b expected 1 0 0", err, count, busy); end
        reset = 0;
        tick();
        reset = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_stream(12, 3, 3, 0);
        test_simul_push_pop();
        test_spurious_reset();
        test_stream(60, 1, 4, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_feed_fifo.md
# tx_feed_fifo

Upstream feeder for the two-flop 4-phase synchronizer's transmit side. Accepts words from the local producer over a valid/ready interface, buffers them in a small FIFO, and presents them one at a time on the synchronizer's `vi`/`sdata` inputs. It holds each word until the synchronizer returns `snt`. The block runs entirely in the transmit clock domain.

## Interface

Parameters:
- `DATA_MSB`, default 7: MSB of the data word; word width is `DATA_MSB+1`.
- `DEPTH`, default 4: FIFO entries; must be a power of two, minimum 2.
- `AW`, default 2: pointer width, log2(`DEPTH`).

Ports:
- `clk`  input  1  transmit-domain clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_data`  input  `DATA_MSB+1`  producer word.
- `in_ready`  output  1  FIFO can accept a word this cycle.
- `vi`  output  1  one-cycle launch pulse to the synchronizer.
- `sdata`  output  `DATA_MSB+1`  word presented to the synchronizer.
- `snt`  input  1  one-cycle pulse from the synchronizer: current word delivered.
- `count`  output  `AW+1`  FIFO occupancy, 0..`DEPTH`.
- `busy`  output  1  a word is in flight (launched, `snt` not yet seen).
- `err`  output  1  sticky flag: `snt` received while no word in flight.

## Operation

- FIFO: circular buffer with `DEPTH` entries.
  - Read and write pointers are `AW` bits wide and wrap naturally.
  - `count` is `AW+1` bits wide.
  - `in_ready = (count != DEPTH)`, combinational from registered `count`.
  - Push: `in_valid && in_ready` writes `in_data` at the write pointer and increments it.
  - Pop: occurs only on accepted `snt` in state WAIT (see below). It increments the read pointer.
  - `count` update: +1 on push only, −1 on pop only, unchanged when push and pop occur together.
  - A full FIFO deasserts `in_ready` even if a pop occurs in the same cycle. Ready depends only on registered `count`.
- FSM with two states, IDLE and WAIT:
  - IDLE with `count != 0`: next edge loads the head entry into the `sdata` register, sets `vi=1` and enters WAIT.
  - IDLE with `count == 0`: stays in IDLE.
  - WAIT: `vi` returns to 0 after exactly one cycle; `sdata` is held stable.
  - WAIT with `snt=1`: pop the head, go to IDLE. The next launch can occur on the following edge.
  - `snt` arriving in the same cycle as `vi=1` is accepted normally.
  - `snt` in IDLE: ignored for the FIFO and FSM; sets `err`. `err` clears only on reset.
- `busy = (state == WAIT)`.
- An entry is not removed until `snt`, so `count` includes the in-flight word.

## Timing

- Reset (`reset=0`, asynchronous) values:
  - state IDLE
  - `vi=0`, `sdata=0`, `busy=0`, `err=0`
  - `count=0`, both pointers 0, `in_ready=1`
- Reset asserted mid-transfer:
  - Drops `vi` and `busy` immediately.
  - Discards all buffered words.
  - Ignores any later `snt` until the next launch, except that such a `snt` sets `err`.
- Latency, push into empty FIFO at edge N:
  - `count=1` after edge N.
  - `vi=1` and `sdata` valid after edge N+1.
  - `busy=1` from edge N+1.
- Release after `snt` sampled at edge M:
  - `busy=0` and the pop take effect after edge M.
  - The next `vi` is emitted after edge M+1 if `count` is still nonzero.
- Throughput: one word per synchronizer round trip plus one IDLE cycle.
- `vi` is never high for two consecutive cycles.
- `sdata` changes only on the edge that raises `vi`.

## Test plan

- **Reset values:** hold reset low → `vi=0`, `sdata=0`, `count=0`, `in_ready=1`, `busy=0`, `err=0`. Release reset with no input → all outputs unchanged for 10 cycles.
- **Single word:** push 8'hA5 at edge N.
  - `count=1` after N; `vi=1` and `sdata=8'hA5` after N+1.
  - Return `snt` 6 cycles later → `count=0`, `busy=0`; no further `vi`.
- **Fill and backpressure:** hold `snt=0` and push 8'h01..8'h05 on consecutive cycles.
  - First four words accepted; `count=4`; `in_ready=0` while 8'h05 waits.
  - Pulse `snt` → 8'h05 is accepted on the cycle after `count` drops to 3.
  - Words then appear on `sdata` in order 01, 02, 03, 04, 05, one `vi` each.
- **Wrap-around:** stream 12 words with `snt` returned 3 cycles after each `vi`, pushing continuously → all 12 are delivered in order and none are lost or duplicated across pointer wrap.
- **Simultaneous push/pop:** with `count=2`, push while `snt` is accepted → `count` stays 2 and order is preserved.
- **Spurious snt, then reset mid-flight:**
  - Pulse `snt` in IDLE → `err=1`; `count` and state unchanged.
  - Push 3 words, then assert reset while `busy=1` → `vi=0`, `count=0`, `err=0` immediately.
